// File: rtl/score_display_pkg.sv
// rtl/score_display_pkg.sv - shared constants, state type and digit helper for the score display
package score_display_pkg;

    localparam int DIGIT_W = 4;

    localparam logic [DIGIT_W-1:0] BLANK_CODE = 4'hF;
    localparam logic [DIGIT_W-1:0] ERR_CODE   = 4'hE;

    typedef enum logic [0:0] {
        ST_BLANK = 1'b0,
        ST_SHOW  = 1'b1
    } state_t;

    // Anything outside 0..9 is not a displayable BCD digit; show the error glyph instead.
    function automatic logic [DIGIT_W-1:0] bcd_sanitize(input logic [DIGIT_W-1:0] digit);
        return (digit > 4'd9) ? ERR_CODE : digit;
    endfunction

endpackage

// File: rtl/rr_next_active.sv
// rtl/rr_next_active.sv - combinational round-robin search for the next active channel
module rr_next_active #(
    parameter int N_PLAYERS = 2
) (
    input  logic [N_PLAYERS-1:0]         mask,
    input  logic [$clog2(N_PLAYERS)-1:0] ptr,
    output logic [$clog2(N_PLAYERS)-1:0] next_idx,
    output logic                         found
);

    localparam int PW = $clog2(N_PLAYERS);

    int ptr_int;

    // Scan ptr+1, ptr+2, ... wrapping around, so the current channel is the last candidate.
    always_comb begin
        ptr_int  = int'(ptr);
        next_idx = ptr;
        found    = 1'b0;
        for (int i = 1; i <= N_PLAYERS; i++) begin
            if (!found && mask[(ptr_int + i) % N_PLAYERS]) begin
                next_idx = PW'((ptr_int + i) % N_PLAYERS);
                found    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/score_display_sequencer.sv
// rtl/score_display_sequencer.sv - multiplexes per-player BCD scores onto one shared digit pair
module score_display_sequencer
    import score_display_pkg::*;
#(
    parameter int N_PLAYERS = 2,
    parameter int DWELL_MS  = 2000,
    parameter int BLANK_MS  = 200
) (
    input  logic                         clk_1khz,
    input  logic                         rst_i,
    input  logic [8*N_PLAYERS-1:0]       scores_i,
    input  logic [N_PLAYERS-1:0]         active_i,
    input  logic                         manual_i,
    input  logic                         next_i,
    output logic [DIGIT_W-1:0]           tens_o,
    output logic [DIGIT_W-1:0]           ones_o,
    output logic [$clog2(N_PLAYERS)-1:0] player_o,
    output logic                         blank_o
);

    localparam int PW      = $clog2(N_PLAYERS);
    localparam int CNT_MAX = (DWELL_MS > BLANK_MS) ? DWELL_MS : BLANK_MS;
    localparam int CNT_W   = ($clog2(CNT_MAX) < 1) ? 1 : $clog2(CNT_MAX);

    localparam logic [CNT_W-1:0] DWELL_LOAD = CNT_W'(DWELL_MS - 1);
    localparam logic [CNT_W-1:0] BLANK_LOAD = CNT_W'(BLANK_MS - 1);
    localparam logic [PW-1:0]    PTR_RESET  = PW'(N_PLAYERS - 1);

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [PW-1:0]      ptr_q, ptr_d;
    logic [DIGIT_W-1:0] tens_q, tens_d;
    logic [DIGIT_W-1:0] ones_q, ones_d;
    logic               blank_q, blank_d;

    logic [PW-1:0]      rr_idx;
    logic               rr_found;
    logic [7:0]         cand_score;
    logic [7:0]         cur_score;
    logic               cur_active;

    rr_next_active #(
        .N_PLAYERS (N_PLAYERS)
    ) u_rr (
        .mask     (active_i),
        .ptr      (ptr_q),
        .next_idx (rr_idx),
        .found    (rr_found)
    );

    assign cand_score = scores_i[8*rr_idx +: 8];
    assign cur_score  = scores_i[8*ptr_q +: 8];
    assign cur_active = active_i[ptr_q];

    // State, counter, pointer and registered display outputs.
    always_ff @(posedge clk_1khz) begin
        if (rst_i) begin
            state_q <= ST_BLANK;
            cnt_q   <= BLANK_LOAD;
            ptr_q   <= PTR_RESET;
            tens_q  <= BLANK_CODE;
            ones_q  <= BLANK_CODE;
            blank_q <= 1'b1;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ptr_q   <= ptr_d;
            tens_q  <= tens_d;
            ones_q  <= ones_d;
            blank_q <= blank_d;
        end
    end

    // Phase sequencing: blanking gap, player search, dwell and the prioritised SHOW exits.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        ptr_d   = ptr_q;
        case (state_q)
            ST_BLANK: begin
                if (cnt_q == '0) begin
                    if (rr_found) begin
                        state_d = ST_SHOW;
                        ptr_d   = rr_idx;
                        cnt_d   = DWELL_LOAD;
                    end else begin
                        cnt_d   = BLANK_LOAD;
                    end
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ST_SHOW: begin
                if (!cur_active || next_i) begin
                    state_d = ST_BLANK;
                    cnt_d   = BLANK_LOAD;
                end else if (manual_i) begin
                    cnt_d = cnt_q;
                end else if (cnt_q == '0) begin
                    state_d = ST_BLANK;
                    cnt_d   = BLANK_LOAD;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: begin
                state_d = ST_BLANK;
                cnt_d   = BLANK_LOAD;
            end
        endcase
    end

    // Next display values: snapshot on SHOW entry, live follow in manual, blank glyphs otherwise.
    always_comb begin
        tens_d  = tens_q;
        ones_d  = ones_q;
        blank_d = (state_d == ST_BLANK);
        if (state_d == ST_BLANK) begin
            tens_d = BLANK_CODE;
            ones_d = BLANK_CODE;
        end else if (state_q == ST_BLANK) begin
            tens_d = bcd_sanitize(cand_score[7:4]);
            ones_d = bcd_sanitize(cand_score[3:0]);
        end else if (manual_i) begin
            tens_d = bcd_sanitize(cur_score[7:4]);
            ones_d = bcd_sanitize(cur_score[3:0]);
        end
    end

    assign tens_o   = tens_q;
    assign ones_o   = ones_q;
    assign player_o = ptr_q;
    assign blank_o  = blank_q;

endmodule
